epc_stack_unit: RTL
===================

Name: epc_stack_unit

Overview:
- Parametrised successor to the single-entry CP0 EPC register.
- Holds a LIFO of DEPTH exception return addresses, so nested exceptions each keep their own EPC and branch-delay (BD) flag.
- Hardware exception entry pushes an entry, ERET pops one, and software MTC0 overwrites the top entry.
- Sits in CP0 beside the Cause/Status logic. Feeds the ERET target to the PC mux and the read path to MFC0.

Parameters:
- DATA_W, 32, width of PC/EPC values.
- DEPTH, 4, number of stacked EPC entries (>=2).
- PC_STEP, 4, byte offset subtracted from pc_p when the faulting instruction sits in a branch delay slot.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we_h  input  1  hardware exception entry: push EPC computed from pc_p/bd_p.
- bd_p  input  1  faulting instruction is in a branch delay slot; sampled with we_h.
- pc_p  input  DATA_W  PC of the faulting instruction; sampled with we_h.
- we_s  input  1  software write (MTC0 EPC) of write_data into the top entry.
- write_data  input  DATA_W  software write value.
- eret  input  1  exception return: pop the top entry.
- r_p  input  1  pipeline (MFC0) read enable.
- r_h  input  1  hardware read enable (ERET target fetch).
- ovf_clr  input  1  clears the sticky overflow flag.
- read_data  output  DATA_W  top EPC when r_p|r_h, else 0.
- epc_top  output  DATA_W  top EPC, always driven (0 when empty).
- bd_top  output  1  BD flag of the top entry (0 when empty).
- depth  output  clog2(DEPTH+1)  number of valid entries.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- overflow  output  1  sticky; set when a push hits a full stack.
- underflow  output  1  one-cycle pulse on eret while empty.

Behaviour:
- Reset (rst=1 at a rising edge):
  - depth=0, all entries=0, all BD flags=0, overflow=0, underflow=0.
  - Reset overrides every other input in the same cycle, including a reset that arrives mid-nesting.
- Push value: EPC = bd_p ? (pc_p - PC_STEP) : pc_p. Computed modulo 2^DATA_W, so pc_p=0 with bd_p=1 gives 0xFFFFFFFC at DATA_W=32. The stored BD flag = bd_p.
- Storage: circular buffer with a top pointer and a saturating count.
- Event priority per cycle: we_h > eret > we_s. Only one operation takes effect:
  - we_h with eret: push only; eret is dropped (exception during return).
  - we_h with we_s: push only; the software write is lost.
  - eret with we_s: pop only.
- Push when not full: the new entry becomes top and depth increments by 1, visible the next cycle.
- Push when full:
  - The oldest entry is overwritten and the new entry becomes top.
  - depth stays DEPTH.
  - overflow is set at the same edge and stays set until ovf_clr or rst.
  - If ovf_clr coincides with a full push, the set wins.
- Pop when depth>0: depth decrements; the previous entry becomes top on the next cycle. The popped entry's contents are not cleared (don't care).
- Pop when empty: no state change; underflow=1 for exactly the following cycle.
- Software write when depth>0: replaces the top entry's EPC; its BD flag is unchanged.
- Software write when empty: creates an entry with EPC=write_data and BD=0; depth becomes 1. This supports the OS seeding EPC before ERET.
- Reads:
  - read_data and epc_top are combinational from the registered top. A read in the same cycle as a write/push returns the pre-edge value.
  - r_p and r_h are equivalent for the data returned; either one enables read_data.
- Latency: one cycle from any write or pop to the updated top/depth/flags.
- empty and full are combinational from depth.

Test Plan:
- Reset then idle: depth=0, empty=1, read_data=0 with r_p=1, epc_top=0, overflow=0.
- Push pc_p=0x00000004, bd_p=0, then push pc_p=0x00000104, bd_p=1:
  - depth=2, epc_top=0x00000100, bd_top=1.
  - After eret: epc_top=0x00000004, bd_top=0.
  - After a second eret: empty=1.
- we_s write_data=0x0000000F while empty: depth=1, read_data=0x0000000F (r_p=1), bd_top=0. Then push pc_p=0x20 with we_s=1 in the same cycle: epc_top=0x20, depth=2.
- DEPTH=4:
  - Push 5 entries 0x10,0x20,0x30,0x40,0x50: overflow=1, depth=4.
  - Four erets return 0x50,0x40,0x30,0x20.
  - A fifth eret gives underflow pulse=1 for one cycle; overflow stays 1 until ovf_clr.
- pc_p=0x00000000 with bd_p=1 pushes 0xFFFFFFFC. Same cycle with eret=1 at depth=1: depth=2 (push wins).
- Assert rst at depth=3: next cycle depth=0, epc_top=0, overflow=0. A push in the reset cycle is ignored.

Source files
------------

// File: rtl/epc_stack_unit.sv
// rtl/epc_stack_unit.sv - LIFO of exception return addresses with BD flags for CP0
module epc_stack_unit #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_h,
    input  logic              bd_p,
    input  logic [DATA_W-1:0] pc_p,
    input  logic              we_s,
    input  logic [DATA_W-1:0] write_data,
    input  logic              eret,
    input  logic              r_p,
    input  logic              r_h,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] epc_top,
    output logic              bd_top,
    output logic [CNT_W-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] epc_mem [DEPTH];
    logic              bd_mem  [DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;

    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [DATA_W-1:0] push_epc;
    logic              do_push;
    logic              do_pop;
    logic              do_swr;

    assign ptr_inc  = (top_ptr == PTR_W'(DEPTH - 1)) ? '0 : top_ptr + PTR_W'(1);
    assign ptr_dec  = (top_ptr == '0) ? PTR_W'(DEPTH - 1) : top_ptr - PTR_W'(1);
    assign push_epc = bd_p ? (pc_p - DATA_W'(PC_STEP)) : pc_p;

    // Only one operation per cycle: hardware entry beats return beats software write.
    assign do_push = we_h;
    assign do_pop  = !we_h && eret;
    assign do_swr  = !we_h && !eret && we_s;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign depth     = count;
    assign epc_top   = empty ? '0 : epc_mem[top_ptr];
    assign bd_top    = empty ? 1'b0 : bd_mem[top_ptr];
    assign read_data = (r_p || r_h) ? epc_top : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                epc_mem[i] <= '0;
                bd_mem[i]  <= 1'b0;
            end
            top_ptr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            underflow <= do_pop && empty;
            if (do_push) begin
                // When full, the slot after top holds the oldest entry, so it is recycled.
                epc_mem[ptr_inc] <= push_epc;
                bd_mem[ptr_inc]  <= bd_p;
                top_ptr          <= ptr_inc;
                if (!full)
                    count <= count + CNT_W'(1);
            end else if (do_pop) begin
                if (!empty) begin
                    top_ptr <= ptr_dec;
                    count   <= count - CNT_W'(1);
                end
            end else if (do_swr) begin
                if (empty) begin
                    epc_mem[ptr_inc] <= write_data;
                    bd_mem[ptr_inc]  <= 1'b0;
                    top_ptr          <= ptr_inc;
                    count            <= CNT_W'(1);
                end else begin
                    epc_mem[top_ptr] <= write_data;
                end
            end
            if (do_push && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
